pc_gen_bp: RTL and testbench

- Parametrised next-generation fetch PC unit. Owns the PC register and selects the next PC from several sources: trap/CSR redirect, EX-stage branch/jump resolution, stall hold, BTB prediction, and sequential increment.
- Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches/jumps are predicted at fetch and corrected from EX.
- Sits between the IF stage, the EX-stage branch resolver and the CSR/trap unit. Supplies the IF PC, the prediction tags that travel down the pipe, and the flush request.

---
 rtl/pc_gen_bp_pkg.sv | 36 +++
 rtl/pc_gen_bp_btb.sv | 71 +++++++
 rtl/pc_gen_bp.sv | 99 +++++++++
 tb/tb_pc_gen_bp.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_bp_pkg.sv
// rtl/pc_gen_bp_pkg.sv - shared types and constants for the fetch PC generator with BTB
package pc_gen_bp_pkg;

    localparam int XLEN       = 64;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_e;

    // Tag and target are stored full width; the BTB compares only the bits above the index.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] target;
        cnt_e            cnt;
    } btb_entry_t;

    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;

    function automatic cnt_e cnt_step(input cnt_e c, input logic up);
        cnt_e r;
        r = c;
        if (up && c != ST) begin
            r = cnt_e'(c + 2'd1);
        end else if (!up && c != SNT) begin
            r = cnt_e'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pc_gen_bp_btb.sv
// rtl/pc_gen_bp_btb.sv - direct-mapped branch target buffer with 2-bit saturating counters
module pc_gen_bp_btb
    import pc_gen_bp_pkg::*;
#(
    parameter int AW    = XLEN,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] i_rd_pc,
    output logic          o_hit,
    output cnt_e          o_cnt,
    output logic [AW-1:0] o_target,
    input  logic          i_upd_en,
    input  logic          i_upd_jmp,
    input  logic          i_upd_taken,
    input  logic [AW-1:0] i_upd_pc,
    input  logic [AW-1:0] i_upd_target
);

    localparam int IDX_W = $clog2(DEPTH);

    btb_entry_t r_mem [DEPTH];

    logic [IDX_W-1:0] w_rd_idx;
    logic [XLEN-1:0]  w_rd_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [XLEN-1:0]  w_up_tag;
    logic             w_up_hit;

    assign w_rd_idx = i_rd_pc[IDX_W+1:2];
    assign w_rd_tag = XLEN'(i_rd_pc >> (IDX_W + 2));
    assign w_up_idx = i_upd_pc[IDX_W+1:2];
    assign w_up_tag = XLEN'(i_upd_pc >> (IDX_W + 2));

    // Read port sees pre-edge contents, so a same-index update is write-after-read.
    assign o_hit    = r_mem[w_rd_idx].valid && (r_mem[w_rd_idx].tag == w_rd_tag);
    assign o_cnt    = r_mem[w_rd_idx].cnt;
    assign o_target = AW'(r_mem[w_rd_idx].target);

    assign w_up_hit = r_mem[w_up_idx].valid && (r_mem[w_up_idx].tag == w_up_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].valid  <= 1'b0;
                r_mem[i].tag    <= '0;
                r_mem[i].target <= '0;
                r_mem[i].cnt    <= WNT;
            end
        end else if (i_upd_en) begin
            if (w_up_hit) begin
                if (i_upd_jmp) begin
                    r_mem[w_up_idx].cnt    <= ST;
                    r_mem[w_up_idx].target <= XLEN'(i_upd_target);
                end else begin
                    r_mem[w_up_idx].cnt <= cnt_step(r_mem[w_up_idx].cnt, i_upd_taken);
                    if (i_upd_taken) begin
                        r_mem[w_up_idx].target <= XLEN'(i_upd_target);
                    end
                end
            end else if (i_upd_taken) begin
                r_mem[w_up_idx].valid  <= 1'b1;
                r_mem[w_up_idx].tag    <= w_up_tag;
                r_mem[w_up_idx].target <= XLEN'(i_upd_target);
                r_mem[w_up_idx].cnt    <= i_upd_jmp ? ST : WT;
            end
        end
    end

endmodule

// File: rtl/pc_gen_bp.sv
// rtl/pc_gen_bp.sv - fetch PC register, next-PC priority mux, mispredict detection and counter
module pc_gen_bp
    import pc_gen_bp_pkg::*;
#(
    parameter int                          XLEN       = pc_gen_bp_pkg::XLEN,
    parameter int                          BTB_DEPTH  = 16,
    parameter logic [XLEN-1:0]             RESET_PC   = '0,
    parameter int                          INST_BYTES = pc_gen_bp_pkg::INST_BYTES,
    parameter int                          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             trap_valid,
    input  logic [XLEN-1:0]  trap_pc,
    input  logic             ex_valid,
    input  logic             ex_is_br,
    input  logic             ex_is_jmp,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic [XLEN-1:0]  pc,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_target,
    output logic             flush,
    output logic [CNT_W-1:0] mispredict_cnt
);

    logic [XLEN-1:0]  r_pc;
    logic [CNT_W-1:0] r_mis_cnt;

    logic             w_res;
    logic             w_act_taken;
    logic             w_mis;
    logic [XLEN-1:0]  w_fix_pc;
    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_hit;
    cnt_e             w_cnt;
    logic [XLEN-1:0]  w_btb_target;

    pc_gen_bp_btb #(
        .AW    (XLEN),
        .DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rd_pc      (r_pc),
        .o_hit        (w_hit),
        .o_cnt        (w_cnt),
        .o_target     (w_btb_target),
        .i_upd_en     (w_res),
        .i_upd_jmp    (ex_is_jmp),
        .i_upd_taken  (w_act_taken),
        .i_upd_pc     (ex_pc),
        .i_upd_target (ex_target)
    );

    assign w_res       = ex_valid & (ex_is_br | ex_is_jmp);
    assign w_act_taken = ex_is_jmp | ex_taken;
    assign w_mis       = w_res & ((w_act_taken != ex_pred_taken) |
                                  (w_act_taken & (ex_target != ex_pred_target)));
    assign w_fix_pc    = w_act_taken ? ex_target : ex_pc + XLEN'(INST_BYTES);
    assign w_seq_pc    = r_pc + XLEN'(INST_BYTES);

    assign pred_taken  = w_hit & w_cnt[1];
    assign pred_target = pred_taken ? w_btb_target : w_seq_pc;
    assign flush       = trap_valid | w_mis;

    // Redirects outrank stall; trap outranks EX correction.
    always_comb begin
        w_next_pc = pred_target;
        if (trap_valid) begin
            w_next_pc = trap_pc;
        end else if (w_mis) begin
            w_next_pc = w_fix_pc;
        end else if (stall) begin
            w_next_pc = r_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_mis_cnt <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_mis && !trap_valid && (r_mis_cnt != {CNT_W{1'b1}})) begin
                r_mis_cnt <= r_mis_cnt + 1'b1;
            end
        end
    end

    assign pc             = r_pc;
    assign mispredict_cnt = r_mis_cnt;

endmodule

// File: tb/tb_pc_gen_bp.sv
// tb/tb_pc_gen_bp.sv - directed table-driven bench for pc_gen_bp
module tb_pc_gen_bp;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        trap_valid;
    logic [63:0] trap_pc;
    logic        ex_valid;
    logic        ex_is_br;
    logic        ex_is_jmp;
    logic        ex_taken;
    logic [63:0] ex_pc;
    logic [63:0] ex_target;
    logic        ex_pred_taken;
    logic [63:0] ex_pred_target;
    logic [63:0] pc;
    logic        pred_taken;
    logic [63:0] pred_target;
    logic        flush;
    logic [2:0]  mispredict_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall;
        logic        trap;
        logic [63:0] tpc;
        logic        exv;
        logic        br;
        logic        jmp;
        logic        tk;
        logic [63:0] epc;
        logic [63:0] etgt;
        logic        ept;
        logic [63:0] eptg;
        logic        fl;
        logic        pt;
        logic [63:0] ptg;
        logic [63:0] npc;
        logic [2:0]  m;
    } vec_t;

    vec_t v [32];
    vec_t t;

    pc_gen_bp #(.CNT_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .ex_valid       (ex_valid),
        .ex_is_br       (ex_is_br),
        .ex_is_jmp      (ex_is_jmp),
        .ex_taken       (ex_taken),
        .ex_pc          (ex_pc),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .pc             (pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .flush          (flush),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check combinational outputs, clock, check registered state.
    task automatic apply(input vec_t x, input int row);
        stall          = x.stall;
        trap_valid     = x.trap;
        trap_pc        = x.tpc;
        ex_valid       = x.exv;
        ex_is_br       = x.br;
        ex_is_jmp      = x.jmp;
        ex_taken       = x.tk;
        ex_pc          = x.epc;
        ex_target      = x.etgt;
        ex_pred_taken  = x.ept;
        ex_pred_target = x.eptg;
        #2;
        chk("flush", row, {63'd0, flush}, {63'd0, x.fl});
        chk("pred_taken", row, {63'd0, pred_taken}, {63'd0, x.pt});
        chk("pred_target", row, pred_target, x.ptg);
        @(posedge clk);
        #1;
        chk("pc", row, pc, x.npc);
        chk("mispredict_cnt", row, {61'd0, mispredict_cnt}, {61'd0, x.m});
    endtask

    initial begin
        //        stall trap tpc        exv br jmp tk epc     etgt     ept eptg      fl pt ptg       npc        m
        v[0]  = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 0, 64'h4,   64'h4,    0};
        v[1]  = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 0, 64'h8,   64'h8,    0};
        v[2]  = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 0, 64'hc,   64'hc,    0};
        v[3]  = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 0, 64'h10,  64'h10,   0};
        v[4]  = '{0, 0, 64'h0,     1, 1, 0, 1, 64'h10, 64'h40,  0, 64'h14,   1, 0, 64'h14,  64'h40,   1};
        v[5]  = '{0, 1, 64'h10,    0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    1, 0, 64'h44,  64'h10,   1};
        v[6]  = '{0, 0, 64'h0,     1, 1, 0, 1, 64'h10, 64'h40,  1, 64'h40,   0, 1, 64'h40,  64'h40,   1};
        v[7]  = '{0, 0, 64'h0,     1, 1, 0, 0, 64'h10, 64'h40,  1, 64'h40,   1, 0, 64'h44,  64'h14,   2};
        v[8]  = '{0, 0, 64'h0,     1, 1, 0, 0, 64'h10, 64'h40,  1, 64'h40,   1, 0, 64'h18,  64'h14,   3};
        v[9]  = '{0, 1, 64'h10,    0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    1, 0, 64'h18,  64'h10,   3};
        v[10] = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 0, 64'h14,  64'h14,   3};
        v[11] = '{1, 1, 64'h8000,  1, 1, 0, 1, 64'h30, 64'h40,  0, 64'h34,   1, 0, 64'h18,  64'h8000, 3};
        v[12] = '{1, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 0, 64'h8004,64'h8000, 3};
        v[13] = '{1, 0, 64'h0,     1, 0, 1, 0, 64'h20, 64'h100, 1, 64'h100,  0, 0, 64'h8004,64'h8000, 3};
        v[14] = '{1, 0, 64'h0,     1, 1, 0, 1, 64'h30, 64'h40,  1, 64'h40,   0, 0, 64'h8004,64'h8000, 3};
        v[15] = '{0, 1, 64'h20,    0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    1, 0, 64'h8004,64'h20,   3};
        v[16] = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 1, 64'h100, 64'h100,  3};
        v[17] = '{0, 1, 64'h30,    0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    1, 0, 64'h104, 64'h30,   3};
        v[18] = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 1, 64'h40,  64'h40,   3};
        v[19] = '{0, 0, 64'h0,     1, 1, 0, 0, 64'h20, 64'h100, 1, 64'h100,  1, 0, 64'h44,  64'h24,   4};
        v[20] = '{0, 1, 64'h20,    0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    1, 0, 64'h28,  64'h20,   4};
        v[21] = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 1, 64'h100, 64'h100,  4};
        v[22] = '{0, 0, 64'h0,     1, 1, 0, 1, 64'h10, 64'h40,  0, 64'h14,   1, 0, 64'h104, 64'h40,   5};
        v[23] = '{0, 1, 64'h10,    0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    1, 0, 64'h44,  64'h10,   5};
        v[24] = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 1, 64'h40,  64'h40,   5};
        v[25] = '{0, 0, 64'h0,     1, 1, 0, 1, 64'h50, 64'h200, 0, 64'h54,   1, 0, 64'h44,  64'h200,  6};
        v[26] = '{0, 1, 64'h10,    0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    1, 0, 64'h204, 64'h10,   6};
        v[27] = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 0, 64'h14,  64'h14,   6};
        v[28] = '{0, 1, 64'h50,    0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    1, 0, 64'h18,  64'h50,   6};
        v[29] = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 1, 64'h200, 64'h200,  6};
        v[30] = '{0, 1, 64'hffff_ffff_ffff_fffc, 0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0, 1, 0, 64'h204, 64'hffff_ffff_ffff_fffc, 6};
        v[31] = '{0, 0, 64'h0,     0, 0, 0, 0, 64'h0,  64'h0,   0, 64'h0,    0, 0, 64'h0,   64'h0,    6};

        rst_n = 1'b0;
        t = v[0];
        t.npc = 64'h0;
        stall = 0; trap_valid = 0; trap_pc = '0; ex_valid = 0; ex_is_br = 0; ex_is_jmp = 0;
        ex_taken = 0; ex_pc = '0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
        #1;
        chk("reset_pc", -1, pc, 64'h0);
        chk("reset_cnt", -1, {61'd0, mispredict_cnt}, 64'h0);
        chk("reset_pred_taken", -1, {63'd0, pred_taken}, 64'h0);
        chk("reset_flush", -1, {63'd0, flush}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            apply(v[i], i);
        end

        // Counter saturation: three more mispredicts from a count of 6.
        for (int k = 0; k < 3; k++) begin
            t = '{0, 0, 64'h0, 1, 1, 0, 1, 64'h400, 64'h40, 0, 64'h404,
                  1, 0, (k == 0) ? 64'h4 : 64'h44, 64'h40, 3'd7};
            apply(t, 100 + k);
        end

        // Reset asserted while a trap redirect is pending: redirect is lost.
        trap_valid = 1'b1;
        trap_pc    = 64'h8000;
        ex_valid   = 1'b0;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_pc", 200, pc, 64'h0);
        chk("rst_mid_cnt", 200, {61'd0, mispredict_cnt}, 64'h0);
        rst_n = 1'b1;
        t = '{0, 1, 64'h50, 0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0, 1, 0, 64'h4, 64'h50, 3'd0};
        apply(t, 201);
        t = '{0, 0, 64'h0, 0, 0, 0, 0, 64'h0, 64'h0, 0, 64'h0, 0, 0, 64'h54, 64'h54, 3'd0};
        apply(t, 202);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
